// File: rtl/rob_wb_arbiter_pkg.sv
// Shared constants for the ROB writeback arbiter: free field values,
// enable/disable levels and default widths.
package rob_wb_arbiter_pkg;

    localparam int DEF_TAG_W  = 4;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_NAME_W = 5;

    localparam logic [DEF_TAG_W-1:0]  TAG_FREE  = '1;
    localparam logic [DEF_DATA_W-1:0] DATA_FREE = '0;
    localparam logic [DEF_NAME_W-1:0] NAME_FREE = '0;

    localparam logic EN  = 1'b1;
    localparam logic DIS = 1'b0;

endpackage

// File: rtl/rob_wb_arbiter_rr_pick.sv
// Circular first-valid finder: scans start, start+1, ... (mod N) and returns
// the first index that is valid and not excluded.
module rob_wb_arbiter_rr_pick
    import rob_wb_arbiter_pkg::*;
#(
    parameter int N     = 4,
    parameter int PTR_W = 2
) (
    input  logic [N-1:0]     valid,
    input  logic [PTR_W-1:0] start,
    input  logic [N-1:0]     excl,
    output logic             found,
    output logic [PTR_W-1:0] idx
);

    always_comb begin
        found = DIS;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            int j;
            j = int'(start) + k;
            if (j >= N) j = j - N;
            if (!found && valid[j] && !excl[j]) begin
                found = EN;
                idx   = PTR_W'(j);
            end
        end
    end

endmodule

// File: rtl/rob_wb_arbiter.sv
// Round-robin writeback arbiter onto ROB ports O and T (1-cycle registered).
// Optional macro ROB_WB_BRANCH_PRIO_EN: requester NUM_REQ-1 always wins port O.
module rob_wb_arbiter
    import rob_wb_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int TAG_W   = DEF_TAG_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int NAME_W  = DEF_NAME_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       rdy,
    input  logic                       flush,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*TAG_W-1:0]   req_tag,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data,
    input  logic [NUM_REQ*NAME_W-1:0]  req_name,
    output logic                       wbo_en,
    output logic [TAG_W-1:0]           wbo_tag,
    output logic [DATA_W-1:0]          wbo_data,
    output logic [NAME_W-1:0]          wbo_name,
    output logic                       wbt_en,
    output logic [TAG_W-1:0]           wbt_tag,
    output logic [DATA_W-1:0]          wbt_data,
    output logic [NAME_W-1:0]          wbt_name
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);

    localparam logic [TAG_W-1:0]  TAG_FREE_W  = {TAG_W{TAG_FREE[0]}};
    localparam logic [DATA_W-1:0] DATA_FREE_W = {DATA_W{DATA_FREE[0]}};
    localparam logic [NAME_W-1:0] NAME_FREE_W = {NAME_W{NAME_FREE[0]}};

`ifdef ROB_WB_BRANCH_PRIO_EN
    // The branch unit is taken out of the rotation and placed on port O directly.
    localparam logic [NUM_REQ-1:0] BASE_EXCL = NUM_REQ'(1) << (NUM_REQ - 1);
`else
    localparam logic [NUM_REQ-1:0] BASE_EXCL = '0;
`endif

    function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_IDX) ? '0 : p + PTR_W'(1);
    endfunction

    function automatic logic [NUM_REQ-1:0] onehot(input logic [PTR_W-1:0] p);
        return NUM_REQ'(1) << p;
    endfunction

    logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic              wbo_en_q, wbo_en_d, wbt_en_q, wbt_en_d;
    logic [TAG_W-1:0]  wbo_tag_q, wbo_tag_d, wbt_tag_q, wbt_tag_d;
    logic [DATA_W-1:0] wbo_data_q, wbo_data_d, wbt_data_q, wbt_data_d;
    logic [NAME_W-1:0] wbo_name_q, wbo_name_d, wbt_name_q, wbt_name_d;

    logic              a_found, b_found;
    logic [PTR_W-1:0]  a_idx, b_idx;
    logic              g0_found, g1_found;
    logic [PTR_W-1:0]  g0_idx, g1_idx, rr_last;

    rob_wb_arbiter_rr_pick #(.N(NUM_REQ), .PTR_W(PTR_W)) u_pick_a (
        .valid (req_valid),
        .start (rr_ptr_q),
        .excl  (BASE_EXCL),
        .found (a_found),
        .idx   (a_idx)
    );

    rob_wb_arbiter_rr_pick #(.N(NUM_REQ), .PTR_W(PTR_W)) u_pick_b (
        .valid (req_valid),
        .start (wrap_inc(a_idx)),
        .excl  (BASE_EXCL | onehot(a_idx)),
        .found (b_found),
        .idx   (b_idx)
    );

    always_comb begin
        g0_found = a_found;
        g0_idx   = a_idx;
        g1_found = b_found;
        g1_idx   = b_idx;
        rr_last  = b_found ? b_idx : a_idx;
`ifdef ROB_WB_BRANCH_PRIO_EN
        if (req_valid[NUM_REQ-1]) begin
            g0_found = EN;
            g0_idx   = LAST_IDX;
            g1_found = a_found;
            g1_idx   = a_idx;
            rr_last  = a_idx;
        end
`endif
    end

    always_comb begin
        req_ready = '0;
        if (rdy && !flush) begin
            if (g0_found) req_ready = req_ready | onehot(g0_idx);
            if (g1_found) req_ready = req_ready | onehot(g1_idx);
        end
    end

    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        wbo_en_d   = wbo_en_q;
        wbo_tag_d  = wbo_tag_q;
        wbo_data_d = wbo_data_q;
        wbo_name_d = wbo_name_q;
        wbt_en_d   = wbt_en_q;
        wbt_tag_d  = wbt_tag_q;
        wbt_data_d = wbt_data_q;
        wbt_name_d = wbt_name_q;
        if (rdy) begin
            if (flush) begin
                rr_ptr_d   = '0;
                wbo_en_d   = DIS;
                wbo_tag_d  = TAG_FREE_W;
                wbo_data_d = DATA_FREE_W;
                wbo_name_d = NAME_FREE_W;
                wbt_en_d   = DIS;
                wbt_tag_d  = TAG_FREE_W;
                wbt_data_d = DATA_FREE_W;
                wbt_name_d = NAME_FREE_W;
            end else begin
                // a_found is exactly "some non-branch requester was granted"
                if (a_found) rr_ptr_d = wrap_inc(rr_last);
                wbo_en_d   = g0_found;
                wbo_tag_d  = g0_found ? req_tag[int'(g0_idx)*TAG_W +: TAG_W]    : TAG_FREE_W;
                wbo_data_d = g0_found ? req_data[int'(g0_idx)*DATA_W +: DATA_W] : DATA_FREE_W;
                wbo_name_d = g0_found ? req_name[int'(g0_idx)*NAME_W +: NAME_W] : NAME_FREE_W;
                wbt_en_d   = g1_found;
                wbt_tag_d  = g1_found ? req_tag[int'(g1_idx)*TAG_W +: TAG_W]    : TAG_FREE_W;
                wbt_data_d = g1_found ? req_data[int'(g1_idx)*DATA_W +: DATA_W] : DATA_FREE_W;
                wbt_name_d = g1_found ? req_name[int'(g1_idx)*NAME_W +: NAME_W] : NAME_FREE_W;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q   <= '0;
            wbo_en_q   <= DIS;
            wbo_tag_q  <= TAG_FREE_W;
            wbo_data_q <= DATA_FREE_W;
            wbo_name_q <= NAME_FREE_W;
            wbt_en_q   <= DIS;
            wbt_tag_q  <= TAG_FREE_W;
            wbt_data_q <= DATA_FREE_W;
            wbt_name_q <= NAME_FREE_W;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            wbo_en_q   <= wbo_en_d;
            wbo_tag_q  <= wbo_tag_d;
            wbo_data_q <= wbo_data_d;
            wbo_name_q <= wbo_name_d;
            wbt_en_q   <= wbt_en_d;
            wbt_tag_q  <= wbt_tag_d;
            wbt_data_q <= wbt_data_d;
            wbt_name_q <= wbt_name_d;
        end
    end

    assign wbo_en   = wbo_en_q;
    assign wbo_tag  = wbo_tag_q;
    assign wbo_data = wbo_data_q;
    assign wbo_name = wbo_name_q;
    assign wbt_en   = wbt_en_q;
    assign wbt_tag  = wbt_tag_q;
    assign wbt_data = wbt_data_q;
    assign wbt_name = wbt_name_q;

endmodule
